// File: rtl/csr_counter_bank_if.sv
// CSR access bus between the execute stage and the counter bank.
// The request is sampled on a clock edge and answered in the following cycle.
interface csr_counter_bank_if;
   logic        csr_req;
   logic [11:0] csr_addr;
   logic [1:0]  csr_op;
   logic [31:0] csr_wdata;
   logic [31:0] csr_rdata;
   logic        csr_rvalid;
   logic        csr_illegal;

   modport master (output csr_req, csr_addr, csr_op, csr_wdata,
                   input  csr_rdata, csr_rvalid, csr_illegal);
   modport slave  (input  csr_req, csr_addr, csr_op, csr_wdata,
                   output csr_rdata, csr_rvalid, csr_illegal);
endinterface

// File: rtl/csr_counter_bank.sv
// mcycle / minstret / mhpmcounter bank with mcountinhibit and registered CSR access.
// Counter slot 0 = mcycle, 1 = minstret, 2+i = mhpmcounter(3+i).
module csr_counter_cell #(
   parameter int CNT_W = 64
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   input  logic             wr_lo,
   input  logic             wr_hi,
   input  logic [31:0]      wdata,
   output logic [CNT_W-1:0] cnt
);
   // A CSR write to either half overrides the increment in the same cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)        cnt <= '0;
      else if (wr_lo) cnt <= {cnt[CNT_W-1:32], wdata};
      else if (wr_hi) cnt <= {wdata[CNT_W-33:0], cnt[31:0]};
      else if (inc)   cnt <= cnt + CNT_W'(1);
   end
endmodule

module csr_counter_bank #(
   parameter int NUM_HPM = 2,
   parameter int CNT_W   = 64
) (
   input  logic               clk,
   input  logic               rst,
   csr_counter_bank_if.slave  bus,
   input  logic               retire,
   input  logic [NUM_HPM-1:0] hpm_event
);
   localparam int          NUM_C    = NUM_HPM + 2;
   localparam logic [31:0] INH_MASK = (32'((64'd1 << NUM_HPM) - 64'd1) << 3) | 32'h5;
   localparam logic [5:0]  HPM_END  = 6'(3 + NUM_HPM);

   typedef struct packed {
      logic       hit;
      logic       illegal;
      logic       hi;
      logic       inh;
      logic [5:0] sel;
   } dec_t;

   dec_t                        dec;
   logic [5:0]                  idx;
   logic                        cnt_ok;
   logic                        user;
   logic [NUM_C-1:0][CNT_W-1:0] cnt;
   logic [CNT_W-1:0]            cnt_sel;
   logic [31:0]                 old_val;
   logic [31:0]                 new_val;
   logic [31:0]                 inh;
   logic                        wr;
   logic                        wr_cnt;
   logic [NUM_C-1:0]            src;
   logic [NUM_C-1:0]            inh_vec;
   logic [NUM_C-1:0]            wr_lo;
   logic [NUM_C-1:0]            wr_hi;
   logic                        vld_q;
   logic [1:0]                  vld_pipe;

   always_comb begin
      idx     = {1'b0, bus.csr_addr[4:0]};
      user    = bus.csr_addr[11:8] == 4'hC;
      cnt_ok  = (bus.csr_addr[11:8] == 4'hB || user) && bus.csr_addr[6:5] == 2'b00 &&
                (idx == 6'd0 || idx == 6'd2 || (idx >= 6'd3 && idx < HPM_END));
      dec     = '0;
      dec.hi  = bus.csr_addr[7];
      dec.inh = bus.csr_addr == 12'h320;
      if (idx == 6'd0)      dec.sel = 6'd0;
      else if (idx == 6'd2) dec.sel = 6'd1;
      else                  dec.sel = idx - 6'd1;
      dec.hit     = cnt_ok || dec.inh;
      // User aliases are read-only; any modifying op there is rejected.
      dec.illegal = !dec.hit || (cnt_ok && user && bus.csr_op != 2'b00);
   end

   always_comb begin
      cnt_sel = '0;
      for (int c = 0; c < NUM_C; c++)
         if (dec.sel == 6'(c)) cnt_sel = cnt[c];
      if (dec.inh)     old_val = inh;
      else if (dec.hi) old_val = 32'(cnt_sel[CNT_W-1:32]);
      else             old_val = cnt_sel[31:0];
      case (bus.csr_op)
         2'b01:   new_val = bus.csr_wdata;
         2'b10:   new_val = old_val | bus.csr_wdata;
         2'b11:   new_val = old_val & ~bus.csr_wdata;
         default: new_val = old_val;
      endcase
   end

   assign wr      = bus.csr_req && !dec.illegal && bus.csr_op != 2'b00;
   assign wr_cnt  = wr && !dec.inh;
   assign src     = {hpm_event, retire, 1'b1};
   assign inh_vec = {inh[3 +: NUM_HPM], inh[2], inh[0]};

   genvar c;
   generate
      for (c = 0; c < NUM_C; c++) begin : g_cnt
         assign wr_lo[c] = wr_cnt && dec.sel == 6'(c) && !dec.hi;
         assign wr_hi[c] = wr_cnt && dec.sel == 6'(c) && dec.hi;
         csr_counter_cell #(.CNT_W(CNT_W)) u_cell (
            .clk   (clk),
            .rst   (rst),
            .inc   (src[c] & ~inh_vec[c]),
            .wr_lo (wr_lo[c]),
            .wr_hi (wr_hi[c]),
            .wdata (new_val),
            .cnt   (cnt[c])
         );
      end
   endgenerate

   // Inhibit updates land at the edge, so the same-cycle increment sees the old value.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                 inh <= '0;
      else if (wr && dec.inh)  inh <= new_val & INH_MASK;
   end

   assign vld_pipe = {vld_q, bus.csr_req};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_q           <= 1'b0;
         bus.csr_illegal <= 1'b0;
         bus.csr_rdata   <= '0;
      end else begin
         vld_q           <= vld_pipe[0];
         bus.csr_illegal <= bus.csr_req && dec.illegal;
         if (bus.csr_req) bus.csr_rdata <= dec.illegal ? 32'h0 : old_val;
      end
   end

   assign bus.csr_rvalid = vld_pipe[1];
endmodule

// File: tb/tb_csr_counter_bank.sv
// Directed bench for csr_counter_bank (NUM_HPM=2, CNT_W=40): timed sequences plus a vector table.
module tb_csr_counter_bank;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       retire = 1'b0;
   logic [1:0] hpm_event = '0;
   int         n_chk = 0;
   int         n_fail = 0;

   csr_counter_bank_if bus ();

   csr_counter_bank #(.NUM_HPM(2), .CNT_W(40)) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .retire    (retire),
      .hpm_event (hpm_event)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  op;
      logic [11:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_rd;
      logic        exp_ill;
   } vec_t;

   vec_t tbl [21];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // One request per call; consecutive calls issue on consecutive edges.
   task automatic do_req(input logic [1:0] op, input logic [11:0] addr, input logic [31:0] wd,
                         output logic [31:0] rd, output logic ill);
      @(negedge clk);
      bus.csr_req = 1'b1; bus.csr_addr = addr; bus.csr_op = op; bus.csr_wdata = wd;
      @(posedge clk); #1;
      bus.csr_req = 1'b0;
      chk("rvalid", 64'(bus.csr_rvalid), 64'd1);
      rd  = bus.csr_rdata;
      ill = bus.csr_illegal;
   endtask

   task automatic req_chk(input string nm, input logic [1:0] op, input logic [11:0] addr,
                          input logic [31:0] wd, input logic [31:0] exp_rd, input logic exp_ill);
      logic [31:0] rd;
      logic        ill;
      do_req(op, addr, wd, rd, ill);
      chk({nm, " rdata"}, 64'(rd), 64'(exp_rd));
      chk({nm, " illegal"}, 64'(ill), 64'(exp_ill));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL timeout: simulation did not finish, expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      tbl[0]  = '{2'b01, 12'h320, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0};
      tbl[1]  = '{2'b00, 12'h320, 32'h0,         32'h0000_001D, 1'b0};
      tbl[2]  = '{2'b01, 12'hB04, 32'h1234_5678, 32'h0,         1'b0};
      tbl[3]  = '{2'b00, 12'hB04, 32'h0,         32'h1234_5678, 1'b0};
      tbl[4]  = '{2'b10, 12'hB04, 32'h0000_000F, 32'h1234_5678, 1'b0};
      tbl[5]  = '{2'b11, 12'hB04, 32'h0000_0070, 32'h1234_567F, 1'b0};
      tbl[6]  = '{2'b00, 12'hC04, 32'h0,         32'h1234_560F, 1'b0};
      tbl[7]  = '{2'b01, 12'hB84, 32'h0000_00AB, 32'h0,         1'b0};
      tbl[8]  = '{2'b00, 12'hC84, 32'h0,         32'h0000_00AB, 1'b0};
      tbl[9]  = '{2'b10, 12'hB84, 32'h0000_0100, 32'h0000_00AB, 1'b0};
      tbl[10] = '{2'b00, 12'hB84, 32'h0,         32'h0000_00AB, 1'b0};
      tbl[11] = '{2'b10, 12'hC04, 32'h0000_0001, 32'h0,         1'b1};
      tbl[12] = '{2'b00, 12'hB01, 32'h0,         32'h0,         1'b1};
      tbl[13] = '{2'b00, 12'hB05, 32'h0,         32'h0,         1'b1};
      tbl[14] = '{2'b00, 12'hB20, 32'h0,         32'h0,         1'b1};
      tbl[15] = '{2'b01, 12'h321, 32'hFFFF_FFFF, 32'h0,         1'b1};
      tbl[16] = '{2'b00, 12'hB04, 32'h0,         32'h1234_560F, 1'b0};
      tbl[17] = '{2'b11, 12'h320, 32'h0000_0010, 32'h0000_001D, 1'b0};
      tbl[18] = '{2'b00, 12'h320, 32'h0,         32'h0000_000D, 1'b0};
      tbl[19] = '{2'b01, 12'h320, 32'h0,         32'h0000_000D, 1'b0};
      tbl[20] = '{2'b00, 12'h320, 32'h0,         32'h0,         1'b0};

      bus.csr_req = 1'b0; bus.csr_addr = '0; bus.csr_op = '0; bus.csr_wdata = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset rvalid", 64'(bus.csr_rvalid), 64'd0);
      chk("reset illegal", 64'(bus.csr_illegal), 64'd0);
      chk("reset rdata", 64'(bus.csr_rdata), 64'd0);

      // Edge numbering starts at the first rising edge after reset release.
      @(negedge clk); rst = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         chk("idle rvalid", 64'(bus.csr_rvalid), 64'd0);
      end
      req_chk("cycle lo", 2'b00, 12'hC00, 32'h0, 32'd10, 1'b0);        // edge 11
      req_chk("cycle hi", 2'b00, 12'hC80, 32'h0, 32'd0, 1'b0);         // edge 12

      req_chk("mcycle wr lo", 2'b01, 12'hB00, 32'hFFFF_FFFF, 32'd12, 1'b0);
      req_chk("mcycle wr hi", 2'b01, 12'hB80, 32'h0, 32'd0, 1'b0);
      req_chk("mcycle no +1", 2'b00, 12'hB00, 32'h0, 32'hFFFF_FFFF, 1'b0);
      req_chk("mcycle carry", 2'b00, 12'hB80, 32'h0, 32'd1, 1'b0);
      req_chk("mcycle lo after", 2'b00, 12'hB00, 32'h0, 32'd1, 1'b0);  // edge 17

      // retire high on edges 18..22; IR inhibited on edges 20,21
      retire = 1'b1;
      req_chk("inh rd0", 2'b00, 12'h320, 32'h0, 32'h0, 1'b0);
      req_chk("inh set IR", 2'b10, 12'h320, 32'h4, 32'h0, 1'b0);
      req_chk("inh rd IR", 2'b00, 12'h320, 32'h0, 32'h4, 1'b0);
      req_chk("inh clr IR", 2'b11, 12'h320, 32'h4, 32'h4, 1'b0);
      req_chk("minstret mid", 2'b00, 12'hB02, 32'h0, 32'd2, 1'b0);
      retire = 1'b0;
      req_chk("minstret", 2'b00, 12'hB02, 32'h0, 32'd3, 1'b0);        // edge 23

      req_chk("inh set CY", 2'b10, 12'h320, 32'h1, 32'h0, 1'b0);      // edge 24
      for (int i = 0; i < 4; i++)
         req_chk("mcycle frozen", 2'b00, 12'hB00, 32'h0, 32'd9, 1'b0);

      req_chk("wr user alias", 2'b01, 12'hC02, 32'h5, 32'h0, 1'b1);
      req_chk("rd unmapped", 2'b00, 12'h7C0, 32'h0, 32'h0, 1'b1);
      req_chk("minstret kept", 2'b00, 12'hB02, 32'h0, 32'd3, 1'b0);

      req_chk("hpm3 wr hi", 2'b01, 12'hB83, 32'hFF, 32'h0, 1'b0);
      req_chk("hpm3 wr lo", 2'b01, 12'hB03, 32'hFFFF_FFFF, 32'h0, 1'b0);
      hpm_event = 2'b01;
      req_chk("hpm3 pre wrap", 2'b00, 12'hB83, 32'h0, 32'hFF, 1'b0);
      hpm_event = 2'b00;
      req_chk("hpm3 wrap lo", 2'b00, 12'hB03, 32'h0, 32'h0, 1'b0);
      req_chk("hpm3 wrap hi", 2'b00, 12'hB83, 32'h0, 32'h0, 1'b0);
      req_chk("hpm3 wr hi wide", 2'b01, 12'hB83, 32'h1FF, 32'h0, 1'b0);
      req_chk("hpm3 hi trunc", 2'b00, 12'hC83, 32'h0, 32'hFF, 1'b0);
      req_chk("hpm3 lo held", 2'b00, 12'hB03, 32'h0, 32'h0, 1'b0);

      retire = 1'b1;
      req_chk("clr vs retire", 2'b11, 12'hB02, 32'hFFFF_FFFF, 32'd3, 1'b0);
      retire = 1'b0;
      req_chk("clr wins", 2'b00, 12'hB02, 32'h0, 32'd0, 1'b0);
      @(posedge clk); #1;
      chk("no req rvalid", 64'(bus.csr_rvalid), 64'd0);

      for (int i = 0; i < 21; i++)
         req_chk($sformatf("vec%0d", i), tbl[i].op, tbl[i].addr, tbl[i].wdata,
                 tbl[i].exp_rd, tbl[i].exp_ill);

      // Reset lands while a response is being presented.
      @(negedge clk);
      bus.csr_req = 1'b1; bus.csr_addr = 12'hB04; bus.csr_op = 2'b00;
      @(posedge clk); #1;
      bus.csr_req = 1'b0;
      rst = 1'b1;
      #1;
      chk("rst mid rvalid", 64'(bus.csr_rvalid), 64'd0);
      chk("rst mid rdata", 64'(bus.csr_rdata), 64'd0);
      @(negedge clk); rst = 1'b0;
      @(posedge clk); #1;
      chk("post rst rvalid", 64'(bus.csr_rvalid), 64'd0);
      req_chk("post rst hpm4", 2'b00, 12'hB04, 32'h0, 32'h0, 1'b0);
      req_chk("post rst inh", 2'b00, 12'h320, 32'h0, 32'h0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
